// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one registered-output ALU between two clients.
// Optional macro ALU_ARB_ZFLAG_EN adds the ZW state and returns the ALU zero flag on rsp_z.
module alu_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [2:0]   req0_op,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp_data,
  output logic         rsp_z,
  output logic         rsp_err,
  output logic [2:0]   alu_op,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in2,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z
);

`ifdef ALU_ARB_ZFLAG_EN
  typedef enum logic [2:0] {IDLE, EXEC, RES, ZW, RSP} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC, RES, RSP} state_t;
`endif

  localparam logic [2:0] OP_MAX = 3'd4;

  state_t         state;
  logic           last_grant;
  logic           id;
  logic           err;
  logic           grant_valid;
  logic           grant_id;
  logic           idle;
  logic [2:0]     sel_op;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;
  assign idle   = (state == IDLE);

  // Ready is masked while reset is held so no client sees an accept during reset.
  assign req0_ready = rst_n && idle && grant_valid && !grant_id;
  assign req1_ready = rst_n && idle && grant_valid &&  grant_id;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      err        <= 1'b0;
      alu_op     <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
`ifdef ALU_ARB_ZFLAG_EN
      rsp_z      <= 1'b0;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_id;
            id         <= grant_id;
            if (sel_op <= OP_MAX) begin
              alu_op  <= sel_op;
              alu_in1 <= sel_a;
              alu_in2 <= sel_b;
              err     <= 1'b0;
              state   <= EXEC;
            end else begin
              // Illegal opcodes never reach the ALU; its inputs keep the last legal op.
              err   <= 1'b1;
              state <= RSP;
            end
          end
        end
        EXEC: state <= RES;
        RES: begin
          rsp_data <= alu_out;
`ifdef ALU_ARB_ZFLAG_EN
          state    <= ZW;
`else
          state    <= RSP;
`endif
        end
`ifdef ALU_ARB_ZFLAG_EN
        ZW: begin
          rsp_z <= alu_z;
          state <= RSP;
        end
`endif
        RSP: begin
          rsp0_valid <= (id == 1'b0);
          rsp1_valid <= (id == 1'b1);
          rsp_err    <= err;
          if (err) begin
            rsp_data <= '0;
`ifdef ALU_ARB_ZFLAG_EN
            rsp_z    <= 1'b0;
`endif
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_ARB_ZFLAG_EN
  assign rsp_z = 1'b0;
  logic unused_alu_z;
  assign unused_alu_z = alu_z;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU attached.
module tb_alu_arbiter;
  localparam int N = 16;
`ifdef ALU_ARB_ZFLAG_EN
  localparam int LAT = 4;
  localparam bit ZEN = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit ZEN = 1'b0;
`endif
  localparam int PERIOD = LAT + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [N-1:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic         rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp_data;
  logic         rsp_z, rsp_err;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_in1, alu_in2;
  logic [N-1:0] alu_out = '0;
  logic         alu_z = 1'b0;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req1_a(req1_a),
    .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: result registered one edge after the inputs, zero flag one edge later.
  always @(posedge clk) begin
    case (alu_op)
      3'd0:    alu_out <= alu_in1;
      3'd1:    alu_out <= alu_in1 + alu_in2;
      3'd2:    alu_out <= alu_in1 - alu_in2;
      3'd3:    alu_out <= alu_in1 * alu_in2;
      3'd4:    alu_out <= alu_in1 << alu_in2[3:0];
      default: alu_out <= '0;
    endcase
    alu_z <= (alu_out == '0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           client;
    logic [N-1:0] data;
    logic         z;
    logic         err;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [2:0]   m_op = '0;
  logic [N-1:0] m_a = '0, m_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a response strobe is seen.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rsp0_valid || rsp1_valid) begin
      check("rsp_onehot", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
      if (q.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        e = q.pop_front();
        check("rsp_client", {31'd0, rsp1_valid}, e.client);
        check("rsp_data", rsp_data, e.data);
        check("rsp_z", {31'd0, rsp_z}, {31'd0, e.z});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check("rsp_cycle", cyc, e.due);
      end
    end
  end

  task automatic set_req(input int c, input logic v, input logic [2:0] op,
                         input logic [N-1:0] a, input logic [N-1:0] b);
    if (c == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic ready_of(input int c);
    return (c == 0) ? req0_ready : req1_ready;
  endfunction

  // Called just before the accepting edge: records the expectation and the model ALU inputs.
  task automatic record(input int c, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] ed, input logic zf,
                        input bit expect_rsp);
    exp_t e;
    bit   illegal;
    illegal  = (op > 3'd4);
    e.client = c;
    e.data   = illegal ? '0 : ed;
    e.z      = (illegal || !ZEN) ? 1'b0 : zf;
    e.err    = illegal;
    e.due    = cyc + 1 + (illegal ? 1 : LAT);
    if (expect_rsp) q.push_back(e);
    if (!illegal) begin
      m_op = op; m_a = a; m_b = b;
    end
  endtask

  task automatic check_alu_regs();
    check("alu_op", {29'd0, alu_op}, {29'd0, m_op});
    check("alu_in1", {16'd0, alu_in1}, {16'd0, m_a});
    check("alu_in2", {16'd0, alu_in2}, {16'd0, m_b});
  endtask

  task automatic issue(input int c, input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] ed, input logic zf,
                       input bit expect_rsp);
    bit got;
    got = 1'b0;
    @(negedge clk);
    set_req(c, 1'b1, op, a, b);
    for (int t = 0; t < 40 && !got; t++) begin
      #1;
      if (ready_of(c)) begin
        got = 1'b1;
        record(c, op, a, b, ed, zf, expect_rsp);
        @(posedge clk);
        #1;
        set_req(c, 1'b0, 3'd0, '0, '0);
        check_alu_regs();
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      set_req(c, 1'b0, 3'd0, '0, '0);
      fail_now("ready_timeout");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      @(posedge clk);
      #2;
    end
    check("drain_pending", q.size(), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    check({tag, "_ready1"}, {31'd0, req1_ready}, 32'd0);
    check({tag, "_rspv"}, {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    check({tag, "_data"}, {16'd0, rsp_data}, 32'd0);
    check({tag, "_zerr"}, {30'd0, rsp_z, rsp_err}, 32'd0);
    check({tag, "_alu"}, {13'd0, alu_op, alu_in1}, 32'd0);
    check({tag, "_in2"}, {16'd0, alu_in2}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    m_op = '0; m_a = '0; m_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Both clients hold valid; expect alternating grants exactly PERIOD cycles apart.
  task automatic dual();
    int order[4] = '{0, 1, 0, 1};
    int last_acc;
    int sent[2];
    bit got;
    last_acc = -1;
    sent[0] = 0;
    sent[1] = 0;
    @(negedge clk);
    set_req(0, 1'b1, 3'd1, 16'd10, 16'd20);
    set_req(1, 1'b1, 3'd2, 16'd7, 16'd9);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          check("dual_ready_onehot", {31'd0, req0_ready && req1_ready}, 32'd0);
          check("dual_grant", {31'd0, req1_ready}, order[k]);
          if (last_acc >= 0) check("dual_spacing", cyc - last_acc, PERIOD);
          last_acc = cyc;
          if (order[k] == 0) record(0, 3'd1, 16'd10, 16'd20, 16'd30, 1'b0, 1'b1);
          else               record(1, 3'd2, 16'd7, 16'd9, 16'hFFFE, 1'b0, 1'b1);
          @(posedge clk);
          #1;
          sent[order[k]]++;
          if (sent[order[k]] == 2) set_req(order[k], 1'b0, 3'd0, '0, '0);
          check_alu_regs();
        end else begin
          @(negedge clk);
        end
      end
      if (!got) fail_now("dual_timeout");
    end
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles with both clients requesting.
    set_req(0, 1'b1, 3'd1, 16'd0, 16'd0);
    set_req(1, 1'b1, 3'd1, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_ready0", {31'd0, req0_ready}, 32'd1);
    check("first_ready1", {31'd0, req1_ready}, 32'd0);
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);

    issue(0, 3'd1, 16'd3, 16'd4, 16'd7, 1'b0, 1'b1);
    issue(1, 3'd2, 16'd5, 16'd5, 16'd0, 1'b1, 1'b1);
    issue(1, 3'd3, 16'hFFFD, 16'd2, 16'hFFFA, 1'b0, 1'b1);
    issue(0, 3'd4, 16'd1, 16'd4, 16'd16, 1'b0, 1'b1);
    issue(1, 3'd0, 16'h1234, 16'h5555, 16'h1234, 1'b0, 1'b1);
    issue(0, 3'd1, 16'h7FFF, 16'd1, 16'h8000, 1'b0, 1'b1);
    issue(0, 3'd6, 16'hAAAA, 16'hBBBB, 16'd0, 1'b0, 1'b1);
    issue(1, 3'd7, 16'h0001, 16'h0002, 16'd0, 1'b0, 1'b1);
    issue(0, 3'd1, 16'hFFFF, 16'd1, 16'd0, 1'b1, 1'b1);
    drain();

    do_reset();
    dual();
    drain();

    // Reset pulsed while the operation sits in RES: no response may follow.
    issue(0, 3'd1, 16'd9, 16'd9, 16'd18, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    m_op = '0; m_a = '0; m_b = '0;
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    issue(0, 3'd1, 16'd1, 16'd1, 16'd2, 1'b0, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
